// File: rtl/tsc_pkg.sv
// -----------------------------------------------------------------------------
// tsc_pkg
// Shared definitions for the event trigger block: counting-mode constants,
// FSM state encoding and a constant-evaluable ceil(log2) helper used to size
// the event counter.
// -----------------------------------------------------------------------------
package tsc_pkg;

  // Counting modes
  localparam int MODE_CUMUL  = 32'sd0;  // count every cycle cond is true
  localparam int MODE_CONSEC = 32'sd1;  // count consecutive cond cycles, restart on a gap
  localparam int MODE_EDGE   = 32'sd2;  // count rising edges of cond

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = 32'(i) + 32'd1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tsc_cond_gen.sv
// -----------------------------------------------------------------------------
// tsc_cond_gen
// Reduces the masked condition channels to a single condition bit, keeps a
// one-cycle history of it (only advanced while enabled) and derives the
// per-cycle qualifying event according to the counting mode.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   i_en     in   history update enable
//   i_clr    in   synchronous clear of the condition history
//   i_mask   in   1 = channel participates
//   i_r      in   condition channel inputs
//   o_cond   out  combinational masked AND of participating channels
//   o_event  out  qualifying event for the selected mode
// -----------------------------------------------------------------------------
module tsc_cond_gen
  import tsc_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int MODE   = MODE_CUMUL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [NUM_IN-1:0] i_mask,
  input  logic [NUM_IN-1:0] i_r,
  output logic              o_cond,
  output logic              o_event
);

  logic w_cond;
  logic r_cond_q;

  // Unmasked channels are forced true for the AND; an all-zero mask never qualifies.
  assign w_cond = (|i_mask) & (&(i_r | ~i_mask));
  assign o_cond = w_cond;

  // Condition history, used by edge mode to spot a 0->1 transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cond_q <= 1'b0;
    end else if (i_clr) begin
      r_cond_q <= 1'b0;
    end else if (i_en) begin
      r_cond_q <= w_cond;
    end else begin
      r_cond_q <= r_cond_q;
    end
  end

  // Event selection per counting mode
  always_comb begin
    o_event = 1'b0;
    case (MODE)
      MODE_CUMUL:  o_event = w_cond;
      MODE_CONSEC: o_event = w_cond;
      MODE_EDGE:   o_event = w_cond & ~r_cond_q;
      default:     o_event = 1'b0;
    endcase
  end

endmodule

// File: rtl/tsc_event_trigger.sv
// -----------------------------------------------------------------------------
// tsc_event_trigger
// N-channel masked trigger condition qualified by a saturating event counter.
// The trigger fires once THRESHOLD qualifying events have been counted while
// armed; it then either holds until clr/reset (STICKY=1) or pulses for one
// cycle and re-arms with a cleared count (STICKY=0).
//
// Ports
//   clk        in   clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   en         in   arm/count enable
//   clr        in   synchronous clear of count, trigger and condition history
//   mask       in   NUM_IN, 1 = channel participates
//   r          in   NUM_IN, condition channel inputs
//   trigger    out  registered trigger (state == FIRED)
//   armed      out  registered armed flag (state == COUNT)
//   hit_count  out  CNT_W, current event count, saturates at THRESHOLD
// -----------------------------------------------------------------------------
module tsc_event_trigger
  import tsc_pkg::*;
#(
  parameter int NUM_IN    = 2,
  parameter int THRESHOLD = 4,
  parameter int MODE      = MODE_CUMUL,
  parameter int STICKY    = 1,
  parameter int CNT_W     = (clog2(THRESHOLD + 1) < 32'd1) ? 32'd1 : int'(clog2(THRESHOLD + 1))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_IN-1:0] mask,
  input  logic [NUM_IN-1:0] r,
  output logic              trigger,
  output logic              armed,
  output logic [CNT_W-1:0]  hit_count
);

  localparam logic [CNT_W-1:0] TH_C = CNT_W'(THRESHOLD);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_trigger;
  logic             r_armed;
  logic             w_cond;
  logic             w_event;

  tsc_cond_gen #(
    .NUM_IN (NUM_IN),
    .MODE   (MODE)
  ) u_cond_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_clr   (clr),
    .i_mask  (mask),
    .i_r     (r),
    .o_cond  (w_cond),
    .o_event (w_event)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1'b1);

  // Next-state and next-count logic; clr overrides enable and any event
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Arming cycle only; counting starts from the next cycle.
          if (en) begin
            w_state_nxt = ST_COUNT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            // Leave counting with the count frozen so a later re-arm resumes it.
            w_state_nxt = ST_IDLE;
          end else if (w_event) begin
            if (r_cnt >= TH_C) begin
              w_state_nxt = ST_FIRED;
              w_cnt_nxt   = TH_C;
            end else if (w_cnt_inc == TH_C) begin
              w_state_nxt = ST_FIRED;
              w_cnt_nxt   = w_cnt_inc;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else if ((MODE == MODE_CONSEC) && !w_cond) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_FIRED: begin
          // Events are ignored here; the count stays saturated until re-arm.
          if (STICKY != 0) begin
            w_state_nxt = ST_FIRED;
          end else begin
            w_cnt_nxt = '0;
            if (en) begin
              w_state_nxt = ST_COUNT;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers; outputs decoded from next state so
  // they change on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_trigger <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_trigger <= (w_state_nxt == ST_FIRED);
      r_armed   <= (w_state_nxt == ST_COUNT);
    end
  end

  assign trigger   = r_trigger;
  assign armed     = r_armed;
  assign hit_count = r_cnt;

endmodule

// File: tb/tb_tsc_event_trigger.sv
// -----------------------------------------------------------------------------
// tb_tsc_event_trigger
// Four instances with different parameter sets share one stimulus bus; each
// scenario starts with clr and checks only the instance it targets.
//   dut 0: TH=4 cumulative sticky    dut 1: TH=3 consecutive sticky
//   dut 2: TH=2 edge sticky          dut 3: TH=1 cumulative pulse
// -----------------------------------------------------------------------------
module tb_tsc_event_trigger;
  import tsc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] mask;
  logic [1:0] r;

  logic       trig0, trig1, trig2, trig3;
  logic       arm0, arm1, arm2, arm3;
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  logic [1:0] cnt2;
  logic [0:0] cnt3;

  int n_checks;
  int n_errors;

  typedef struct {
    int         dut;
    logic       clr;
    logic       en;
    logic [1:0] mask;
    logic [1:0] r;
    logic       e_trig;
    logic       e_armed;
    int         e_cnt;
  } vec_t;

  vec_t vecs[$];

  tsc_event_trigger #(.NUM_IN(2), .THRESHOLD(4), .MODE(MODE_CUMUL), .STICKY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mask(mask), .r(r),
    .trigger(trig0), .armed(arm0), .hit_count(cnt0));
  tsc_event_trigger #(.NUM_IN(2), .THRESHOLD(3), .MODE(MODE_CONSEC), .STICKY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mask(mask), .r(r),
    .trigger(trig1), .armed(arm1), .hit_count(cnt1));
  tsc_event_trigger #(.NUM_IN(2), .THRESHOLD(2), .MODE(MODE_EDGE), .STICKY(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mask(mask), .r(r),
    .trigger(trig2), .armed(arm2), .hit_count(cnt2));
  tsc_event_trigger #(.NUM_IN(2), .THRESHOLD(1), .MODE(MODE_CUMUL), .STICKY(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mask(mask), .r(r),
    .trigger(trig3), .armed(arm3), .hit_count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge trig0) $display("Trojan Activated");
  always @(posedge trig1) $display("Trojan Activated");
  always @(posedge trig2) $display("Trojan Activated");
  always @(posedge trig3) $display("Trojan Activated");

  function automatic logic [31:0] get_trig(input int d);
    case (d)
      0: return {31'd0, trig0};
      1: return {31'd0, trig1};
      2: return {31'd0, trig2};
      3: return {31'd0, trig3};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] get_armed(input int d);
    case (d)
      0: return {31'd0, arm0};
      1: return {31'd0, arm1};
      2: return {31'd0, arm2};
      3: return {31'd0, arm3};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int d);
    case (d)
      0: return {29'd0, cnt0};
      1: return {30'd0, cnt1};
      2: return {30'd0, cnt2};
      3: return {31'd0, cnt3};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int d, input logic t, input logic a, input int c);
    check($sformatf("%s.dut%0d.trigger", tag, d), get_trig(d), {31'd0, t});
    check($sformatf("%s.dut%0d.armed", tag, d), get_armed(d), {31'd0, a});
    check($sformatf("%s.dut%0d.hit_count", tag, d), get_cnt(d), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int d, input logic c, input logic e, input logic [1:0] m,
                     input logic [1:0] rr, input logic t, input logic a, input int n);
    vec_t v;
    v.dut = d; v.clr = c; v.en = e; v.mask = m; v.r = rr;
    v.e_trig = t; v.e_armed = a; v.e_cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mask = 2'b00; r = 2'b00;

    // ---- Vector table: {dut, clr, en, mask, r} -> {trigger, armed, hit_count}
    // Scenario 1: cumulative, TH=4, sticky
    add(0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 0);
    add(0, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 0);  // arming cycle
    add(0, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1);
    add(0, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 2);
    add(0, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2);  // gap does not reset
    add(0, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 3);
    add(0, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 4);  // fires
    for (int i = 0; i < 12; i++) begin                // holds, events ignored
      add(0, 1'b0, (i % 3) != 0, 2'b11, 2'(i), 1'b1, 1'b0, 4);
    end
    // Scenario 2: consecutive, TH=3
    add(1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 0);
    add(1, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 0);
    add(1, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1);
    add(1, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 2);
    add(1, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 0);  // gap resets
    add(1, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1);
    add(1, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 2);
    add(1, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 3);
    // Scenario 3: rising edges, TH=2
    add(2, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 0);
    add(2, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 0);
    add(2, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin                 // level held: no new edges
      add(2, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1);
    end
    add(2, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1);
    add(2, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 2);
    // Scenario 4: TH=1 pulse mode
    add(3, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 0);
    add(3, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 0);
    add(3, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1);
    add(3, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 0);
    add(3, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1);
    add(3, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 0);
    add(3, 1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1);
    add(3, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 0);  // en low ends pulse into IDLE
    add(3, 1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 0);
    // Scenario 5a: partial mask, r[1] is don't-care
    add(0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 0);
    add(0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 0);
    add(0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 1);
    add(0, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 2);
    add(0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 2);

    // ---- Reset state of all instances (asynchronous, before any clock edge)
    #2;
    for (int d = 0; d < 4; d++) begin
      check_dut("reset", d, 1'b0, 1'b0, 0);
    end
    #10;
    rst_n = 1'b1;

    // ---- Table run
    foreach (vecs[i]) begin
      clr  = vecs[i].clr;
      en   = vecs[i].en;
      mask = vecs[i].mask;
      r    = vecs[i].r;
      tick();
      check_dut($sformatf("vec%0d", i), vecs[i].dut, vecs[i].e_trig, vecs[i].e_armed, vecs[i].e_cnt);
    end

    // ---- Scenario 5b: empty mask never qualifies
    clr = 1'b1; en = 1'b0; tick();
    clr = 1'b0; en = 1'b1; mask = 2'b00; r = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mask0.trigger", {31'd0, trig0}, 32'd0);
    end
    check_dut("mask0.end", 0, 1'b0, 1'b1, 0);

    // ---- Scenario 6a: en low freezes the count, re-arm resumes it
    clr = 1'b1; en = 1'b0; mask = 2'b11; r = 2'b00; tick();
    clr = 1'b0; en = 1'b1; tick();
    r = 2'b11; tick(); tick();
    check_dut("freeze.pre", 0, 1'b0, 1'b1, 2);
    en = 1'b0; tick();
    check_dut("freeze.off", 0, 1'b0, 1'b0, 2);
    tick();
    check_dut("freeze.hold", 0, 1'b0, 1'b0, 2);
    en = 1'b1; tick();
    check_dut("freeze.rearm", 0, 1'b0, 1'b1, 2);
    tick();
    check_dut("freeze.resume", 0, 1'b0, 1'b1, 3);

    // ---- Scenario 6b: asynchronous reset mid-count
    clr = 1'b1; en = 1'b0; r = 2'b00; tick();
    clr = 1'b0; en = 1'b1; tick();
    r = 2'b11; tick(); tick();
    check_dut("rst.pre", 0, 1'b0, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_dut("rst.async", 0, 1'b0, 1'b0, 0);
    #2;
    rst_n = 1'b1;

    // ---- Scenario 6c: clr while fired, takes effect on the next edge
    tick();
    check_dut("clr.arm", 0, 1'b0, 1'b1, 0);
    tick(); tick(); tick(); tick();
    check_dut("clr.fired", 0, 1'b1, 1'b0, 4);
    clr = 1'b1;
    #2;
    check("clr.before_edge.trigger", {31'd0, trig0}, 32'd1);
    tick();
    check_dut("clr.after", 0, 1'b0, 1'b0, 0);
    clr = 1'b0; en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
